// File: rtl/led_pkg.sv
// Shared types and widths for the LED pattern controller.
package led_pkg;

    localparam int unsigned CFG_VAL_W = 16;
    localparam int unsigned PWM_W     = 8;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned CH_W      = 4;

    typedef enum logic [MODE_W-1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2,
        PWM   = 2'd3
    } led_mode_e;

    // Per-channel configuration payload held by each channel.
    typedef struct packed {
        led_mode_e            mode;
        logic [CFG_VAL_W-1:0] val;
    } led_cfg_t;

    // A blink half-period of zero behaves as one millisecond.
    function automatic logic [CFG_VAL_W-1:0] eff_period(input logic [CFG_VAL_W-1:0] v);
        return (v == '0) ? CFG_VAL_W'(1) : v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_HZ/1000-1 and flags the last count
// with a registered one-cycle tick.
module led_tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_ms_o
);

    localparam int unsigned DIV   = CLK_HZ / 1000;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Tick is registered alongside the count so it is high exactly while cnt_q == LAST.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_ms_o = tick_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM patterns with a
// shared ms tick and PWM counter, configured through a single write port.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned N_LED          = 4,
    parameter int unsigned DEF_PERIOD_MS  = 1000,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic                 FPGA_CLK,
    input  logic                 FPGA_RST,
    input  logic                 cfg_wr,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [MODE_W-1:0]    cfg_mode,
    input  logic [CFG_VAL_W-1:0] cfg_val,
    output logic                 tick_ms,
    output logic [N_LED-1:0]     F_LED
);

    localparam int unsigned CHK_W = CH_W + 1;
    localparam logic [N_LED-1:0] LED_POL = {N_LED{LED_ACTIVE_LOW}};

    logic             tick_c;
    logic             cfg_hit_c;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic [N_LED-1:0] state_c;
    logic [N_LED-1:0] led_q, led_d;

    led_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk_i     (FPGA_CLK),
        .rst_i     (FPGA_RST),
        .tick_ms_o (tick_c)
    );

    // Extra bit on the compare keeps N_LED = 16 from aliasing to zero.
    assign cfg_hit_c = cfg_wr && ({1'b0, cfg_ch} < CHK_W'(N_LED));

    always_comb begin
        pwm_d = pwm_q + PWM_W'(1);
    end

    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    for (genvar i = 0; i < int'(N_LED); i++) begin : g_ch
        led_cfg_t             cfg_q, cfg_d;
        logic [CFG_VAL_W-1:0] ms_q, ms_d;
        logic                 st_q, st_d;
        logic                 sel_c;

        assign sel_c = cfg_hit_c && (cfg_ch == CH_W'(i));

        // A write wins over a same-cycle tick; the tick is simply lost for this channel.
        always_comb begin
            cfg_d = cfg_q;
            ms_d  = ms_q;
            st_d  = st_q;
            if (sel_c) begin
                cfg_d.mode = led_mode_e'(cfg_mode);
                cfg_d.val  = cfg_val;
                ms_d       = '0;
                st_d       = 1'b0;
            end else begin
                case (cfg_q.mode)
                    OFF: st_d = 1'b0;
                    ON:  st_d = 1'b1;
                    BLINK: begin
                        if (tick_c) begin
                            if (ms_q == eff_period(cfg_q.val) - CFG_VAL_W'(1)) begin
                                st_d = ~st_q;
                                ms_d = '0;
                            end else begin
                                ms_d = ms_q + CFG_VAL_W'(1);
                            end
                        end
                    end
                    PWM:     st_d = (pwm_q < cfg_q.val[PWM_W-1:0]);
                    default: st_d = 1'b0;
                endcase
            end
        end

        always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
            if (FPGA_RST) begin
                cfg_q.mode <= BLINK;
                cfg_q.val  <= CFG_VAL_W'(DEF_PERIOD_MS);
                ms_q       <= '0;
                st_q       <= 1'b0;
            end else begin
                cfg_q <= cfg_d;
                ms_q  <= ms_d;
                st_q  <= st_d;
            end
        end

        assign state_c[i] = st_q;
    end

    always_comb begin
        led_d = state_c ^ LED_POL;
    end

    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            led_q <= LED_POL;
        end else begin
            led_q <= led_d;
        end
    end

    assign tick_ms = tick_c;
    assign F_LED   = led_q;

endmodule
